param_csa_resolver: RTL and testbench

PARAM_CSA_RESOLVER -- requirements
Module: param_csa_resolver

---
 rtl/param_csa_resolver.sv | 143 ++++++++++++++
 tb/tb_param_csa_resolver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_csa_resolver.sv
// ============================================================================
// Module      : param_csa_resolver
// Description : Resolves a carry-save (sum, carry) pair into a binary value,
//               CHUNK bits per clock, with valid/ready handshakes on both
//               sides. result = sum_in + (carry_in << 1), WIDTH+2 bits wide.
// Option      : define CSA_RESOLVE_APPROX_EN to replace the chunk-0 add by a
//               bitwise OR with no carry into chunk 1 (timing unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_csa_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   sum_in,
  input  logic [WIDTH-1:0]   carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   result,
  output logic               busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // Operands are kept WIDTH+2 wide so the carry vector can sit pre-shifted.
  logic [WIDTH+1:0]   opa;
  logic [WIDTH+1:0]   opb;
  logic [WIDTH+1:0]   res;
  logic [CW-1:0]      cnt;
  logic               carry;

  logic               accept;
  logic               last;
  int                 idx;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic [1:0]         top_sum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    last      = (cnt == LAST_CHUNK);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Chunk adder: current slice of both operands plus the stored carry.
  always_comb begin
    idx       = int'(cnt) * CHUNK;
    a_chunk   = opa[idx +: CHUNK];
    b_chunk   = opb[idx +: CHUNK];
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
`ifdef CSA_RESOLVE_APPROX_EN
    if (cnt == '0) begin
      chunk_sum = {1'b0, a_chunk | b_chunk};
    end
`else
`endif
    top_sum = opa[WIDTH+1:WIDTH] + opb[WIDTH+1:WIDTH] + {1'b0, chunk_sum[CHUNK]};
  end

  // Operand capture on accept only; chunk-by-chunk result build during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      opa   <= {2'b00, sum_in};
      opb   <= {1'b0, carry_in, 1'b0};
      cnt   <= '0;
      carry <= 1'b0;
    end else if (state == RUN) begin
      res[idx +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry             <= chunk_sum[CHUNK];
      if (last) begin
        res[WIDTH+1:WIDTH] <= top_sum;
        cnt                <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign result = res;

endmodule

`default_nettype wire

// File: tb/tb_param_csa_resolver.sv
// ============================================================================
// Module      : tb_param_csa_resolver
// Description : Self-checking bench for param_csa_resolver (WIDTH=16,
//               CHUNK=4). A transaction-level model tracks each accepted
//               operation and its age; one compare process checks the DUT
//               against it every cycle. Directed vectors also carry
//               hand-computed literal results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_csa_resolver;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int NC = W / CH;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   sum_in;
  logic [W-1:0]   carry_in;
  logic           out_valid;
  logic           out_ready;
  logic [W+1:0]   result;
  logic           busy;

  int             checks;
  int             errors;

  logic           lit_en;
  logic [W+1:0]   lit_exp;

  // Model state: one outstanding operation, its age in edges, its value.
  logic           m_pending;
  int             m_age;
  logic [W+1:0]   m_exp;

  param_csa_resolver #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic value the resolver must produce for one operand pair.
  function automatic logic [W+1:0] ref_res(input logic [W-1:0] s, input logic [W-1:0] c);
    logic [W+1:0] a;
    logic [W+1:0] b;
    logic [W+1:0] mask;
    a    = {2'b00, s};
    b    = {1'b0, c, 1'b0};
    mask = (W+2)'((1 << CH) - 1);
`ifdef CSA_RESOLVE_APPROX_EN
    return (((a >> CH) + (b >> CH)) << CH) | ((a | b) & mask);
`else
    if (mask == '0) return '0;
    return a + b;
`endif
  endfunction

  // Transaction model: accept when idle, complete NC edges later,
  // retire on an out_ready edge once complete.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_age     <= 0;
      m_exp     <= '0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending <= 1'b1;
        m_age     <= 0;
        m_exp     <= ref_res(sum_in, carry_in);
      end
    end else if (m_age < NC) begin
      m_age <= m_age + 1;
    end else if (out_ready) begin
      m_pending <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_result",    result, '0);
      chk("rst_out_valid", {17'd0, out_valid}, 18'd0);
      chk("rst_in_ready",  {17'd0, in_ready},  18'd1);
      chk("rst_busy",      {17'd0, busy},      18'd0);
    end else begin
      chk("in_ready",  {17'd0, in_ready},  {17'd0, !m_pending});
      chk("busy",      {17'd0, busy},      {17'd0, m_pending});
      chk("out_valid", {17'd0, out_valid}, {17'd0, (m_pending && m_age == NC)});
      if (m_pending && m_age == NC) begin
        chk("result_model", result, m_exp);
        if (lit_en) begin
          chk("result_literal", result, lit_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full operation with out_ready high: accept, run, one DONE cycle.
  task automatic op(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W+1:0] lit);
    sum_in   = s;
    carry_in = c;
    lit_exp  = lit;
    lit_en   = 1'b1;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(NC + 1);
    lit_en   = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sum_in    = '0;
    carry_in  = '0;
    out_ready = 1'b1;
    lit_en    = 1'b0;
    lit_exp   = '0;
    step(3);

    // Release reset and present an operand at once: first edge must accept.
    rst_n = 1'b1;
    op(16'h1234, 16'h0000, 18'h01234);
`ifdef CSA_RESOLVE_APPROX_EN
    op(16'hFFFF, 16'hFFFF, 18'h2FFEF);
    op(16'hA5A5, 16'h5A5A, 18'h15A55);
`else
    op(16'hFFFF, 16'hFFFF, 18'h2FFFD);
    op(16'hA5A5, 16'h5A5A, 18'h15A59);
`endif
    op(16'h0001, 16'h8000, 18'h10001);
    op(16'h0000, 16'h0000, 18'h00000);

    // Backpressure in DONE with a competing operand on the input.
    out_ready = 1'b0;
    sum_in    = 16'h0F0F;
    carry_in  = 16'h00F0;
    lit_exp   = 18'h010EF;
    lit_en    = 1'b1;
    in_valid  = 1'b1;
    step(1);
    in_valid  = 1'b0;
    step(NC);
    sum_in    = 16'h1111;
    carry_in  = 16'h1111;
    in_valid  = 1'b1;
    step(5);
    out_ready = 1'b1;
    step(1);
    lit_exp   = 18'h03333;
    step(1);
    in_valid  = 1'b0;
    step(NC + 1);

    // in_valid held through RUN with different operands.
    sum_in   = 16'h00FF;
    carry_in = 16'h0001;
`ifdef CSA_RESOLVE_APPROX_EN
    lit_exp  = 18'h000FF;
`else
    lit_exp  = 18'h00101;
`endif
    in_valid = 1'b1;
    step(1);
    sum_in   = 16'h0003;
    carry_in = 16'h0002;
    step(NC);
    step(1);
    lit_exp  = 18'h00007;
    step(1);
    in_valid = 1'b0;
    step(NC + 1);

    // Reset while chunk 2 is next to be processed.
    sum_in   = 16'h1357;
    carry_in = 16'h2468;
    lit_en   = 1'b0;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(2);
    rst_n    = 1'b0;
    step(2);
    rst_n    = 1'b1;
    step(NC + 2);
    op(16'h4321, 16'h0102, 18'h04525);

    // Random regression: operands change every cycle, in_valid and
    // out_ready toggle randomly.
    lit_en = 1'b0;
    for (int i = 0; i < 18000; i++) begin
      sum_in    = W'($urandom);
      carry_in  = W'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(NC + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
